// File: rtl/weight_row_mac_ctrl_if.sv
// Weight BRAM port, input-buffer port and loader handshake shared between
// weight_row_mac_ctrl (master) and the memories/loader around it (slave).
interface weight_row_mac_ctrl_if #(
  parameter int AW = 5,
  parameter int DW = 16
);
  logic [AW-1:0] bram_addr;
  logic          bram_en;
  logic          bram_we;
  logic [DW-1:0] bram_di;
  logic [DW-1:0] w_data;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_data;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  modport master (
    output bram_addr, bram_en, bram_we, bram_di, x_addr, ld_ready,
    input  w_data, x_data, ld_valid, ld_addr, ld_data
  );

  modport slave (
    input  bram_addr, bram_en, bram_we, bram_di, x_addr, ld_ready,
    output w_data, x_data, ld_valid, ld_addr, ld_data
  );
endinterface

// File: rtl/weight_row_mac_ctrl.sv
// Weight-row sequencer and BRAM port arbiter: Q8.8 dot product of one weight row with
// the input buffer. Define WEIGHT_LOAD_EN to enable the loader write port.
module weight_row_mac_ctrl #(
  parameter int DEPTH = 28,
  parameter int AW    = 5,
  parameter int DW    = 16,
  parameter int ACC_W = 40
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] result_o,
  output logic          result_sat_o,
  weight_row_mac_ctrl_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  state_t                   state_q, state_d;
  logic [AW-1:0]            addr_q, addr_d;
  logic                     en_q, en_d;
  logic                     we_q, we_d;
  logic [DW-1:0]            di_q, di_d;
  logic                     drain_q, drain_d;
  logic                     done_q;
  logic [DW-1:0]            result_q;
  logic                     sat_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     vld_p0, vld_p1;
  logic signed [DW-1:0]     w_p0, x_p0;
  logic signed [2*DW-1:0]   prod_p1;
  logic                     ld_accept;
  logic [DW:0]              sat_res;

  // Arithmetic shift back to Q8.8, clipping to the signed DW-bit range; MSB flags a clip.
  function automatic logic [DW:0] sat_q88(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> 8;
    if (s > SAT_MAX)      return {1'b1, SAT_MAX[DW-1:0]};
    else if (s < SAT_MIN) return {1'b1, SAT_MIN[DW-1:0]};
    else                  return {1'b0, s[DW-1:0]};
  endfunction

`ifdef WEIGHT_LOAD_EN
  assign bus.ld_ready = (state_q == S_IDLE) && !start_i;
  assign ld_accept    = bus.ld_valid && bus.ld_ready && (32'(bus.ld_addr) < DEPTH);
`else
  logic unused_ld;
  assign unused_ld    = ^{bus.ld_valid, bus.ld_addr, bus.ld_data};
  assign bus.ld_ready = 1'b0;
  assign ld_accept    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    en_d    = 1'b0;
    we_d    = 1'b0;
    di_d    = di_q;
    drain_d = drain_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          addr_d  = '0;
          en_d    = 1'b1;
        end else if (ld_accept) begin
          addr_d = bus.ld_addr;
          en_d   = 1'b1;
          we_d   = 1'b1;
          di_d   = bus.ld_data;
        end
      end
      S_RUN: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end else begin
          addr_d = addr_q + 1'b1;
          en_d   = 1'b1;
        end
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = S_OUT;
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign sat_res = sat_q88(acc_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      di_q     <= '0;
      drain_q  <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      sat_q    <= 1'b0;
      acc_q    <= '0;
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      we_q    <= we_d;
      di_q    <= di_d;
      drain_q <= drain_d;
      done_q  <= (state_q == S_OUT);
      // p0: read data captured the cycle after its address was driven
      vld_p0  <= en_q && !we_q;
      // p1: product registered
      vld_p1  <= vld_p0;
      // p2: accumulate, or emit result and clear in OUT
      if (state_q == S_OUT) begin
        result_q <= sat_res[DW-1:0];
        sat_q    <= sat_res[DW];
        acc_q    <= '0;
      end else if (vld_p1) begin
        acc_q <= acc_q + {{(ACC_W-2*DW){prod_p1[2*DW-1]}}, prod_p1};
      end
    end
  end

  // Datapath registers carry no reset; the vld_pN flags qualify them.
  always_ff @(posedge clk) begin
    w_p0    <= bus.w_data;
    x_p0    <= bus.x_data;
    prod_p1 <= w_p0 * x_p0;
  end

  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = done_q;
  assign result_o      = result_q;
  assign result_sat_o  = sat_q;
  assign bus.bram_addr = addr_q;
  assign bus.x_addr    = addr_q;
  assign bus.bram_en   = en_q;
`ifdef WEIGHT_LOAD_EN
  assign bus.bram_we   = we_q;
  assign bus.bram_di   = di_q;
`else
  logic unused_wr;
  assign unused_wr     = ^{we_q, di_q};
  assign bus.bram_we   = 1'b0;
  assign bus.bram_di   = '0;
`endif

endmodule
